// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD register-window controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_EN_HI    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_EXEC     = 3'd5,
    ST_IDLE     = 3'd6
  } lcd_state_t;

  // Power-on init commands: 8-bit/2-line, display on, clear, entry mode.
  localparam int unsigned INIT_LEN = 4;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Store-data bit positions.
  localparam int unsigned BIT_ON   = 31;
  localparam int unsigned BIT_CTRL = 30;
  localparam int unsigned BIT_RS   = 9;

  // Status read-back bit positions.
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_INIT_DONE = 1;
  localparam int unsigned STAT_OVERRUN   = 2;

  // Register window decoded by the LSU input mux.
  localparam logic [15:0] LCD_ADDR = 16'h7030;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_controller_timer.sv
// Loadable down-counter; o_done flags the last cycle of the current state.
module lcd_timer #(
  parameter int          W       = 8,
  parameter int unsigned RST_VAL = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Reload on state entry, otherwise count down and park at 1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt > W'(1)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/lcd_controller.sv
// Turns CPU stores into timed HD44780 write cycles and runs power-on init.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 80000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_data,
  output logic [31:0] o_lcd_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int unsigned P_MAX = max_u(max_u(max_u(T_PWR, T_SETUP), max_u(T_EN, T_HOLD)),
                                        max_u(T_EXEC, T_CLEAR));
  localparam int CW = $clog2(P_MAX) + 1;

  lcd_state_t    r_state, w_next;
  logic          r_busy, r_en, r_rs, r_on, r_overrun, r_init_done;
  logic [7:0]    r_data;
  logic [2:0]    r_init_idx;
  logic          w_done, w_load, w_init_issue, w_is_clear;
  logic          w_strobe_ctrl, w_strobe_cmd, w_accept;
  logic [CW-1:0] w_load_val;
  logic          w_unused_data;

  assign w_strobe_ctrl = i_lcd_wr &&  i_lcd_data[BIT_CTRL];
  assign w_strobe_cmd  = i_lcd_wr && !i_lcd_data[BIT_CTRL];
  assign w_accept      = w_strobe_cmd && (r_state == ST_IDLE);
  assign w_is_clear    = !r_rs && (r_data[7:2] == '0) && (r_data[1:0] != '0);
  assign w_unused_data = ^{i_lcd_data[29:10], i_lcd_data[8]};

  // Next-state selection.
  always_comb begin
    w_next       = r_state;
    w_init_issue = 1'b0;
    case (r_state)
      ST_PWR_WAIT: if (w_done) w_next = ST_INIT;
      ST_INIT:     w_next = ST_INIT;
      ST_SETUP:    if (w_done) w_next = ST_EN_HI;
      ST_EN_HI:    if (w_done) w_next = ST_HOLD;
      ST_HOLD:     if (w_done) w_next = ST_EXEC;
      ST_EXEC:     if (w_done) w_next = (r_init_idx == 3'(INIT_LEN)) ? ST_IDLE : ST_INIT;
      ST_IDLE:     if (w_accept) w_next = ST_SETUP;
      default:     w_next = ST_PWR_WAIT;
    endcase
    // INIT occupies no cycle: it resolves straight into SETUP for the next ROM entry
    if (w_next == ST_INIT) begin
      w_init_issue = 1'b1;
      w_next       = ST_SETUP;
    end
  end

  // Dwell time of the state being entered.
  always_comb begin
    w_load_val = '0;
    case (w_next)
      ST_SETUP: w_load_val = CW'(T_SETUP);
      ST_EN_HI: w_load_val = CW'(T_EN);
      ST_HOLD:  w_load_val = CW'(T_HOLD);
      ST_EXEC:  w_load_val = w_is_clear ? CW'(T_CLEAR) : CW'(T_EXEC);
      default:  w_load_val = CW'(T_PWR);
    endcase
  end

  assign w_load = (w_next != r_state);

  lcd_timer #(
    .W       (CW),
    .RST_VAL (T_PWR)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // State register plus registered busy/EN/init progress.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_PWR_WAIT;
      r_busy      <= 1'b1;
      r_en        <= 1'b0;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_en    <= (w_next == ST_EN_HI);
      if (w_init_issue) r_init_idx <= r_init_idx + 3'd1;
      if (w_next == ST_IDLE) r_init_done <= 1'b1;
    end
  end

  // LCD bus: ROM entries during init, latched store data afterwards.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data <= '0;
      r_rs   <= 1'b0;
      r_on   <= 1'b0;
    end else begin
      if (r_state == ST_PWR_WAIT) r_on <= 1'b1;
      if (w_init_issue) begin
        r_data <= INIT_ROM[r_init_idx[1:0]];
        r_rs   <= 1'b0;
      end else if (w_accept) begin
        r_data <= i_lcd_data[7:0];
        r_rs   <= i_lcd_data[BIT_RS];
        r_on   <= i_lcd_data[BIT_ON];
      end
    end
  end

  // Sticky overrun: set by a dropped command, cleared by a control write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (w_strobe_ctrl) begin
      r_overrun <= 1'b0;
    end else if (w_strobe_cmd && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Status word assembly.
  always_comb begin
    o_lcd_status                 = '0;
    o_lcd_status[STAT_BUSY]      = r_busy;
    o_lcd_status[STAT_INIT_DONE] = r_init_done;
    o_lcd_status[STAT_OVERRUN]   = r_overrun;
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_on   = r_on;

endmodule

// File: doc/lcd_controller.md
# lcd_controller

Memory-mapped responder for the LCD register window (0x7030) driven by the load-store unit. It turns each CPU write into a timed HD44780 write cycle (setup, EN pulse, hold, execution wait) and runs the power-on init sequence in hardware. It reports busy and status back for CPU polling, which replaces software bit-banging of EN/RS.

## Interface

Parameters (defaults are cycle counts at 50 MHz; benches override with small values):
- T_PWR, 750000, power-on wait before init (15 ms)
- T_SETUP, 4, RS/DATA valid before EN rises (80 ns)
- T_EN, 25, EN high width (500 ns)
- T_HOLD, 4, RS/DATA held after EN falls (80 ns)
- T_EXEC, 2000, post-command wait for normal commands and data (40 us)
- T_CLEAR, 80000, post-command wait for clear/home (1.6 ms)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_lcd_wr  in  1  one-cycle strobe, LSU store to 0x7030
- i_lcd_data  in  32  store data: [31] ON, [30] CTRL, [9] RS, [7:0] DATA; other bits ignored
- o_lcd_status  out  32  read-back: [0] busy, [1] init_done, [2] overrun, rest 0
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write, held at 0 (write-only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  panel power/backlight

## Operation

- States: PWR_WAIT, INIT, SETUP, EN_HI, HOLD, EXEC, IDLE.
- Reset: state is PWR_WAIT. o_lcd_data=0, rs=0, rw=0, en=0, on=0, busy=1, init_done=0, overrun=0.
- PWR_WAIT: o_lcd_on=1. After T_PWR cycles, go to INIT with init index 0.
- INIT: load init ROM entry (RS=0): 0x38, 0x0C, 0x01, 0x06. Run one command cycle. Return to INIT with index+1. After entry 3 completes, set init_done=1 and go to IDLE.
- Command cycle: SETUP for T_SETUP cycles, then EN_HI for T_EN cycles (en=1), then HOLD for T_HOLD cycles, then EXEC.
- EXEC wait length is T_CLEAR when RS=0, DATA[7:2]=0 and DATA[1:0]≠0. Otherwise it is T_EXEC.
- IDLE, strobe with [30]=0: latch DATA to o_lcd_data, RS to o_lcd_rs, [31] to o_lcd_on. Start a command cycle.
- Strobe with [30]=1 (any state): control write. Clears overrun. No command is issued, no outputs change, and it never counts as overrun.
- Strobe with [30]=0 while not IDLE, including during init: the write is dropped and overrun is set (sticky).
- busy = (state ≠ IDLE). o_lcd_rw is constantly 0.
- Counter width is $clog2 of the largest parameter plus 1. A single down-counter is reloaded on each state entry. A state exits when the counter reaches 1. Every parameter must be ≥1.

## Timing

- All outputs are registered.
- A strobe sampled at edge k in IDLE produces these responses:
  - busy=1, data/rs/on updated from edge k.
  - en=1 from edge k+T_SETUP to edge k+T_SETUP+T_EN.
  - busy=0 at edge k+T_SETUP+T_EN+T_HOLD+Tw, where Tw is T_EXEC or T_CLEAR.
- The earliest next accepted strobe is at the edge where busy is first sampled 0. A strobe at the edge that clears busy is dropped and sets overrun.
- o_lcd_data and o_lcd_rs are stable from SETUP through the end of HOLD. They keep their values in IDLE.
- Init takes T_PWR + 3·(T_SETUP+T_EN+T_HOLD+T_EXEC) + (T_SETUP+T_EN+T_HOLD+T_CLEAR) cycles. Entry 0x01 uses T_CLEAR.
- A control write and a dropped command cannot occur in the same cycle, because there is only one strobe. Clear takes priority over set.
- Reset asserted mid-cycle forces en=0 and all other reset values immediately (asynchronously). Init restarts from PWR_WAIT on release.

## Structure

- Package lcd_pkg holds:
  - the state enum
  - the init ROM as a localparam array of 4×8 bits
  - bit-position constants ON=31, CTRL=30, RS=9, status BUSY=0, INIT_DONE=1, OVERRUN=2
  - the address constant 0x7030
- Sub-module lcd_timer: a loadable down-counter with load value, load strobe and a done flag. It is parameterised by counter width.
- Address decode stays in the LSU input mux. This block only sees i_lcd_wr.

## Test plan

1. Init: set all parameters small (T_PWR=10, T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLEAR=20). After release, the bench must see exactly four EN pulses with data 0x38, 0x0C, 0x01, 0x06 and RS=0. The gap after 0x01 is 20 cycles. init_done=1 and busy=0 at the computed cycle.
2. Data write: after init, strobe 0x8000_0241 (RS=1, 'A', ON=1). o_lcd_data=0x41 and rs=1 from the next edge; en high for exactly 3 cycles starting 2 cycles later; busy high for 12 cycles.
3. Clear detect: strobe 0x8000_0001 gives a 20-cycle EXEC. Strobe 0x8000_0002 also gives 20 cycles. Strobe 0x8000_0004 gives a 5-cycle EXEC.
4. Overrun: strobe during EN_HI. The in-flight command is unaffected, the bus is unchanged and overrun=1. Strobe 0x4000_0000 clears overrun with no EN pulse and busy unchanged.
5. Back-to-back: strobe on the edge busy clears is dropped (overrun=1). A strobe one cycle later is accepted.
6. Reset mid-EN: assert i_reset while en=1. en, on, data and rs go to 0 without a clock edge. After release, the full init sequence repeats.
